// File: rtl/rvv_xrf_wb_pkg.sv
// Shared types and helpers for the vector-to-scalar writeback queue.
package rvv_xrf_wb_pkg;

    localparam int XRF_ADDR_W = 5;
    localparam int XRF_DATA_W = 32;

    typedef struct packed {
        logic [XRF_ADDR_W-1:0] addr;
        logic [XRF_DATA_W-1:0] data;
    } XrfWbEntry;

    // Assumes ptr < depth and inc <= depth, so one conditional subtract wraps.
    function automatic int ptr_add(int ptr, int inc, int depth);
        int s;
        s = ptr + inc;
        if (s >= depth) s = s - depth;
        return s;
    endfunction

endpackage

// File: rtl/rvv_xrf_wb_queue_if.sv
// Retire-side and regfile-side handshakes of the writeback queue.
interface rvv_xrf_wb_queue_if #(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 1,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
);

    logic [NUM_IN-1:0]              in_valid;
    logic [NUM_IN-1:0][ADDR_W-1:0]  in_addr;
    logic [NUM_IN-1:0][DATA_W-1:0]  in_data;
    logic [NUM_IN-1:0]              in_ready;
    logic [NUM_OUT-1:0]             out_valid;
    logic [NUM_OUT-1:0][ADDR_W-1:0] out_addr;
    logic [NUM_OUT-1:0][DATA_W-1:0] out_data;
    logic [NUM_OUT-1:0]             out_ready;

    modport master (
        output in_valid, in_addr, in_data, out_ready,
        input  in_ready, out_valid, out_addr, out_data
    );

    modport slave (
        input  in_valid, in_addr, in_data, out_ready,
        output in_ready, out_valid, out_addr, out_data
    );

endinterface

// File: rtl/rvv_xrf_wb_queue_compactor.sv
// Prefix-count compaction: maps each write offset to its source retire slot.
module rvv_wb_compactor #(
    parameter  int NUM_IN = 4,
    localparam int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    localparam int CNT_W  = $clog2(NUM_IN + 1)
) (
    input  logic [NUM_IN-1:0]            mask,
    output logic [NUM_IN-1:0][IDX_W-1:0] src_sel,
    output logic [NUM_IN-1:0]            sel_valid,
    output logic [CNT_W-1:0]             push
);

    int pos;

    always_comb begin
        src_sel   = '0;
        sel_valid = '0;
        pos       = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (mask[i]) begin
                src_sel[pos]   = IDX_W'(i);
                sel_valid[pos] = 1'b1;
                pos            = pos + 1;
            end
        end
        push = CNT_W'(pos);
    end

endmodule

// File: rtl/rvv_xrf_wb_queue.sv
// In-order multi-slot buffer from vector retire slots to scalar regfile ports.
module rvv_xrf_wb_queue
    import rvv_xrf_wb_pkg::*;
#(
    parameter  int NUM_IN  = 4,
    parameter  int NUM_OUT = 1,
    parameter  int DEPTH   = 8,
    parameter  int DATA_W  = 32,
    parameter  int ADDR_W  = 5,
    localparam int FILL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    rvv_xrf_wb_queue_if.slave wb,
    output logic [FILL_W-1:0] fill_level
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int PUSH_W = $clog2(NUM_IN + 1);

    if (DEPTH < NUM_IN || DEPTH < NUM_OUT) begin : g_bad_depth
        $error("rvv_xrf_wb_queue: DEPTH must be >= NUM_IN and >= NUM_OUT");
    end
    if (DATA_W > XRF_DATA_W || ADDR_W > XRF_ADDR_W) begin : g_bad_width
        $error("rvv_xrf_wb_queue: DATA_W/ADDR_W exceed XrfWbEntry fields");
    end

    logic [PTR_W-1:0]  rd_ptr, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_d;
    logic [FILL_W-1:0] count, count_d;
    XrfWbEntry         mem [DEPTH];

    logic [NUM_IN-1:0]            accept;
    logic [NUM_IN-1:0]            store_mask;
    logic [NUM_IN-1:0]            sel_valid;
    logic [NUM_IN-1:0][IDX_W-1:0] src_sel;
    logic [PUSH_W-1:0]            push;
    logic [NUM_OUT-1:0]           xfer;
    logic [PTR_W-1:0]             rd_idx;
    logic                         gap;
    logic                         order_err;
    int                           free;
    int                           pop_n;

    // Readiness comes from registered occupancy only, giving a prefix mask.
    always_comb begin
        free        = DEPTH - int'(count);
        wb.in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            wb.in_ready[i] = !flush && (free >= i + 1);
        end
    end

    always_comb begin
        accept     = wb.in_valid & wb.in_ready;
        store_mask = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            store_mask[i] = accept[i] && (|wb.in_addr[i]);
        end
    end

    rvv_wb_compactor #(
        .NUM_IN (NUM_IN)
    ) u_compactor (
        .mask      (store_mask),
        .src_sel   (src_sel),
        .sel_valid (sel_valid),
        .push      (push)
    );

    always_comb begin
        wb.out_valid = '0;
        wb.out_addr  = '0;
        wb.out_data  = '0;
        rd_idx       = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            rd_idx          = PTR_W'(ptr_add(int'(rd_ptr), k, DEPTH));
            wb.out_valid[k] = !flush && (int'(count) > k);
            wb.out_addr[k]  = mem[rd_idx].addr[ADDR_W-1:0];
            wb.out_data[k]  = mem[rd_idx].data[DATA_W-1:0];
        end
    end

    // Only the leading run of transferring ports retires entries.
    always_comb begin
        xfer      = wb.out_valid & wb.out_ready;
        pop_n     = 0;
        gap       = 1'b0;
        order_err = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (!xfer[k]) gap = 1'b1;
            else if (gap) order_err = 1'b1;
            else pop_n = pop_n + 1;
        end
    end

    always_comb begin
        count_d  = FILL_W'(int'(count) + int'(push) - pop_n);
        wr_ptr_d = PTR_W'(ptr_add(int'(wr_ptr), int'(push), DEPTH));
        rd_ptr_d = PTR_W'(ptr_add(int'(rd_ptr), pop_n, DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count_d;
            rd_ptr <= rd_ptr_d;
            wr_ptr <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int o = 0; o < NUM_IN; o++) begin
                if (sel_valid[o]) begin
                    mem[PTR_W'(ptr_add(int'(wr_ptr), o, DEPTH))] <= '{
                        addr: XRF_ADDR_W'(wb.in_addr[src_sel[o]]),
                        data: XRF_DATA_W'(wb.in_data[src_sel[o]])
                    };
                end
            end
        end
    end

    assign fill_level = count;

    a_out_order: assert property (@(posedge clk) disable iff (rst) !order_err);

endmodule

// File: tb/tb_rvv_xrf_wb_queue.sv
// Directed self-checking bench for rvv_xrf_wb_queue (DEPTH 8 and DEPTH 6).
module tb_rvv_xrf_wb_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush_a = 1'b0;
    logic       flush_b = 1'b0;
    logic [3:0] fill_a;
    logic [2:0] fill_b;

    int checks   = 0;
    int failures = 0;
    int x0_seen  = 0;

    always #5 clk = ~clk;

    rvv_xrf_wb_queue_if #(.NUM_IN(4), .NUM_OUT(1), .DATA_W(32), .ADDR_W(5)) a_if ();
    rvv_xrf_wb_queue_if #(.NUM_IN(4), .NUM_OUT(1), .DATA_W(32), .ADDR_W(5)) b_if ();

    rvv_xrf_wb_queue #(
        .NUM_IN(4), .NUM_OUT(1), .DEPTH(8), .DATA_W(32), .ADDR_W(5)
    ) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a), .wb(a_if), .fill_level(fill_a)
    );

    rvv_xrf_wb_queue #(
        .NUM_IN(4), .NUM_OUT(1), .DEPTH(6), .DATA_W(32), .ADDR_W(5)
    ) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .wb(b_if), .fill_level(fill_b)
    );

    always @(posedge clk) begin
        if (!rst && a_if.out_valid[0] && a_if.out_addr[0] == 5'd0) x0_seen++;
        if (!rst && b_if.out_valid[0] && b_if.out_addr[0] == 5'd0) x0_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_a(input int slot, input logic [4:0] addr, input logic [31:0] data);
        a_if.in_addr[slot] = addr;
        a_if.in_data[slot] = data;
    endtask

    logic [4:0]  q_addr [$];
    logic [31:0] q_data [$];
    int sent;
    int rcvd;
    int n;

    initial begin
        a_if.in_valid = '0; a_if.in_addr = '0; a_if.in_data = '0; a_if.out_ready = '0;
        b_if.in_valid = '0; b_if.in_addr = '0; b_if.in_data = '0; b_if.out_ready = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_in_ready", a_if.in_ready, 4'b1111);
        chk("rst_out_valid", a_if.out_valid, 1'b0);
        chk("rst_fill", fill_a, 4'd0);
        chk("rst_b_in_ready", b_if.in_ready, 4'b1111);
        chk("rst_b_fill", fill_b, 3'd0);

        // Slots 0,2,3 valid with a hole at slot 1.
        @(negedge clk);
        a_if.in_valid = 4'b1101;
        set_a(0, 5'd5, 32'h105); set_a(1, 5'd1, 32'h101);
        set_a(2, 5'd7, 32'h107); set_a(3, 5'd9, 32'h109);
        #2;
        chk("no_bypass", a_if.out_valid, 1'b0);
        @(negedge clk);
        a_if.in_valid = '0;
        #2;
        chk("hole_fill", fill_a, 4'd3);
        chk("hole_head_valid", a_if.out_valid, 1'b1);
        chk("hole_head_addr", a_if.out_addr[0], 5'd5);
        chk("hole_head_data", a_if.out_data[0], 32'h105);
        @(negedge clk);
        a_if.out_ready = 1'b1;
        #2;
        chk("drain0_addr", a_if.out_addr[0], 5'd5);
        @(negedge clk); #2;
        chk("drain1_addr", a_if.out_addr[0], 5'd7);
        chk("drain1_fill", fill_a, 4'd2);
        @(negedge clk); #2;
        chk("drain2_addr", a_if.out_addr[0], 5'd9);
        chk("drain2_data", a_if.out_data[0], 32'h109);
        chk("drain2_fill", fill_a, 4'd1);
        @(negedge clk);
        a_if.out_ready = 1'b0;
        #2;
        chk("drained_valid", a_if.out_valid, 1'b0);
        chk("drained_fill", fill_a, 4'd0);

        // x0 on slot 1 is consumed, not stored.
        @(negedge clk);
        a_if.in_valid = 4'b0011;
        set_a(0, 5'd3, 32'h33); set_a(1, 5'd0, 32'hdead);
        #2;
        chk("x0_ready", a_if.in_ready, 4'b1111);
        @(negedge clk);
        a_if.in_valid = '0;
        #2;
        chk("x0_fill", fill_a, 4'd1);
        chk("x0_addr", a_if.out_addr[0], 5'd3);
        chk("x0_data", a_if.out_data[0], 32'h33);
        @(negedge clk);
        a_if.out_ready = 1'b1;
        #2;
        @(negedge clk);
        a_if.out_ready = 1'b0;
        #2;
        chk("x0_drained", fill_a, 4'd0);

        // Fill to 6 of 8, then overrun attempt.
        @(negedge clk);
        a_if.in_valid = 4'b1111;
        set_a(0, 5'd1, 32'h201); set_a(1, 5'd2, 32'h202);
        set_a(2, 5'd3, 32'h203); set_a(3, 5'd4, 32'h204);
        #2;
        @(negedge clk);
        a_if.in_valid = 4'b0011;
        set_a(0, 5'd5, 32'h205); set_a(1, 5'd6, 32'h206);
        #2;
        chk("fill4_ready", a_if.in_ready, 4'b1111);
        @(negedge clk);
        a_if.in_valid = '0;
        #2;
        chk("fill6_level", fill_a, 4'd6);
        chk("fill6_ready", a_if.in_ready, 4'b0011);
        @(negedge clk);
        a_if.in_valid = 4'b1111;
        set_a(0, 5'd10, 32'h20a); set_a(1, 5'd11, 32'h20b);
        set_a(2, 5'd12, 32'h20c); set_a(3, 5'd13, 32'h20d);
        #2;
        chk("over_ready", a_if.in_ready, 4'b0011);
        @(negedge clk);
        a_if.in_valid = '0;
        #2;
        chk("full_level", fill_a, 4'd8);
        chk("full_ready", a_if.in_ready, 4'b0000);
        chk("full_head", a_if.out_addr[0], 5'd1);
        @(negedge clk);
        a_if.out_ready = 1'b1;
        #2;
        @(negedge clk); #2;
        chk("full_drain_a", a_if.out_addr[0], 5'd2);
        chk("full_drain_fill", fill_a, 4'd7);
        chk("freed_ready", a_if.in_ready, 4'b0001);
        @(negedge clk); #2;
        chk("full_drain_b", a_if.out_addr[0], 5'd3);

        // Flush with 5 buffered, 2 incoming and out_ready high.
        @(negedge clk);
        flush_a = 1'b1;
        a_if.in_valid = 4'b0011;
        set_a(0, 5'd20, 32'h300); set_a(1, 5'd21, 32'h301);
        #2;
        chk("flush_pre_fill", fill_a, 4'd5);
        chk("flush_out_valid", a_if.out_valid, 1'b0);
        chk("flush_in_ready", a_if.in_ready, 4'b0000);
        @(negedge clk);
        flush_a = 1'b0;
        a_if.in_valid = '0;
        a_if.out_ready = 1'b0;
        #2;
        chk("flush_fill", fill_a, 4'd0);
        chk("flush_valid_after", a_if.out_valid, 1'b0);
        chk("flush_ready_after", a_if.in_ready, 4'b1111);
        @(negedge clk);
        a_if.in_valid = 4'b0100;
        set_a(2, 5'd14, 32'h314);
        #2;
        @(negedge clk);
        a_if.in_valid = '0;
        #2;
        chk("post_flush_fill", fill_a, 4'd1);
        chk("post_flush_addr", a_if.out_addr[0], 5'd14);
        chk("post_flush_data", a_if.out_data[0], 32'h314);

        // DEPTH=6 streaming 1-in/1-out with scoreboard.
        sent = 0;
        rcvd = 0;
        n    = 0;
        while (n < 60 && rcvd < 20) begin
            @(negedge clk);
            b_if.out_ready = 1'b1;
            b_if.in_valid  = (sent < 20) ? 4'b0001 : 4'b0000;
            b_if.in_addr[0] = 5'(sent % 31 + 1);
            b_if.in_data[0] = 32'hb000 + 32'(sent);
            #2;
            if (b_if.out_valid[0]) begin
                if (q_addr.size() == 0) begin
                    chk("sb_spurious", b_if.out_valid, 1'b0);
                end else begin
                    chk("sb_addr", b_if.out_addr[0], q_addr.pop_front());
                    chk("sb_data", b_if.out_data[0], q_data.pop_front());
                end
                rcvd++;
            end
            if (b_if.in_valid[0] && b_if.in_ready[0]) begin
                q_addr.push_back(b_if.in_addr[0]);
                q_data.push_back(b_if.in_data[0]);
                sent++;
            end
            n++;
        end
        chk("sb_rcvd", rcvd, 20);
        chk("sb_throughput", n, 21);
        @(negedge clk);
        b_if.in_valid  = '0;
        b_if.out_ready = '0;
        #2;
        chk("sb_fill_end", fill_b, 3'd0);
        chk("sb_valid_end", b_if.out_valid, 1'b0);
        chk("no_x0_out", x0_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
